// File: rtl/cache_control_nway.sv
// rtl/cache_control_nway.sv - N-way write-back cache controller FSM with burst sequencing and flush walk
module cache_control_nway #(
    parameter int NUM_WAYS  = 4,
    parameter int NUM_SETS  = 8,
    parameter int BURST_LEN = 4,
    localparam int WAY_W    = $clog2(NUM_WAYS),
    localparam int SET_W    = $clog2(NUM_SETS),
    localparam int BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic [NUM_WAYS-1:0] hit,
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] dirty,
    input  logic [WAY_W-1:0]    plru_way,
    output logic [WAY_W-1:0]    hit_way,
    output logic                plru_update,
    output logic                set_dirty,
    output logic [WAY_W-1:0]    way_sel,
    output logic [BEAT_W-1:0]   beat,
    output logic                wb_rd,
    output logic                alloc_we,
    output logic                alloc_done,
    output logic                clear_dirty,
    input  logic                flush_req,
    output logic                flush_active,
    output logic [SET_W-1:0]    flush_set,
    output logic                flush_done,
    output logic                pmem_read,
    output logic                pmem_write,
    input  logic                pmem_resp
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WRITE_BACK = 3'd1;
    localparam logic [2:0] S_ALLOCATE   = 3'd2;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
    localparam logic [2:0] S_FLUSH_WB   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WAY_W-1:0]  way_sel_q, way_sel_d;
    logic [SET_W-1:0]  flush_set_q, flush_set_d;
    logic              flush_done_q, flush_done_d;

    logic              req;
    logic              last_beat;
    logic              last_way;
    logic              last_set;
    logic [WAY_W-1:0]  victim;
    logic              advance;

    function automatic logic [WAY_W-1:0] lowest_set(input logic [NUM_WAYS-1:0] v);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (v[i]) idx = WAY_W'(i);
        end
        return idx;
    endfunction

    assign req       = mem_read | mem_write;
    assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign last_way  = (way_sel_q == WAY_W'(NUM_WAYS - 1));
    assign last_set  = (flush_set_q == SET_W'(NUM_SETS - 1));
    // Fill invalid ways before evicting anything; PLRU only decides among a full set.
    assign victim    = (~valid != '0) ? lowest_set(~valid) : plru_way;

    assign hit_way    = lowest_set(hit);
    assign way_sel    = way_sel_q;
    assign beat       = beat_q;
    assign flush_set  = flush_set_q;
    assign flush_done = flush_done_q;

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        way_sel_d    = way_sel_q;
        flush_set_d  = flush_set_q;
        flush_done_d = 1'b0;
        advance      = 1'b0;
        mem_resp     = 1'b0;
        plru_update  = 1'b0;
        set_dirty    = 1'b0;
        wb_rd        = 1'b0;
        alloc_we     = 1'b0;
        alloc_done   = 1'b0;
        clear_dirty  = 1'b0;
        flush_active = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (hit != '0) begin
                        mem_resp    = 1'b1;
                        plru_update = 1'b1;
                        set_dirty   = mem_write;
                    end else begin
                        way_sel_d = victim;
                        state_d   = (valid[victim] && dirty[victim]) ? S_WRITE_BACK : S_ALLOCATE;
                    end
                end else if (flush_req) begin
                    state_d     = S_FLUSH_SCAN;
                    flush_set_d = '0;
                    way_sel_d   = '0;
                end
            end
            S_WRITE_BACK, S_FLUSH_WB: begin
                pmem_write   = 1'b1;
                wb_rd        = 1'b1;
                flush_active = (state_q == S_FLUSH_WB);
                if (pmem_resp) begin
                    if (last_beat) begin
                        beat_d = '0;
                        if (state_q == S_WRITE_BACK) begin
                            state_d = S_ALLOCATE;
                        end else begin
                            clear_dirty = 1'b1;
                            advance     = 1'b1;
                        end
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                alloc_we  = pmem_resp;
                if (pmem_resp) begin
                    if (last_beat) begin
                        alloc_done = 1'b1;
                        beat_d     = '0;
                        state_d    = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            S_FLUSH_SCAN: begin
                flush_active = 1'b1;
                if (valid[way_sel_q] && dirty[way_sel_q]) begin
                    state_d = S_FLUSH_WB;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Way and set wrap together after the final line, leaving both at zero for the next flush.
        if (advance) begin
            state_d   = S_FLUSH_SCAN;
            way_sel_d = way_sel_q + WAY_W'(1);
            if (last_way) begin
                flush_set_d = flush_set_q + SET_W'(1);
                if (last_set) begin
                    state_d      = S_IDLE;
                    flush_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            beat_q       <= '0;
            way_sel_q    <= '0;
            flush_set_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            way_sel_q    <= way_sel_d;
            flush_set_q  <= flush_set_d;
            flush_done_q <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_cache_control_nway.sv
// tb/tb_cache_control_nway.sv - scoreboard bench for cache_control_nway
module tb_cache_control_nway;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write, mem_resp;
    logic [3:0] hit, valid, dirty;
    logic [1:0] plru_way, hit_way, way_sel, beat;
    logic       plru_update, set_dirty, wb_rd, alloc_we, alloc_done, clear_dirty;
    logic       flush_req, flush_active, flush_done;
    logic [2:0] flush_set;
    logic       pmem_read, pmem_write, pmem_resp;

    always #5 clk = ~clk;

    cache_control_nway #(.NUM_WAYS(4), .NUM_SETS(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .valid(valid), .dirty(dirty), .plru_way(plru_way),
        .hit_way(hit_way), .plru_update(plru_update), .set_dirty(set_dirty),
        .way_sel(way_sel), .beat(beat), .wb_rd(wb_rd),
        .alloc_we(alloc_we), .alloc_done(alloc_done), .clear_dirty(clear_dirty),
        .flush_req(flush_req), .flush_active(flush_active), .flush_set(flush_set),
        .flush_done(flush_done),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    logic [19:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          fa_cnt = 0;
    int          fd_cnt = 0;
    int          ad_cnt = 0;
    int          resp_mode = 0;
    int          probe_kind = 0;
    logic [31:0] probe_exp;
    string       probe_name;

    // Event record: resp fields, burst fields, flush_done.
    function automatic logic [19:0] rec(input logic mr, input logic pu, input logic sd,
                                        input logic [1:0] hw, input logic prd, input logic pwr,
                                        input logic wbrd, input logic [1:0] bt, input logic [1:0] ws,
                                        input logic awe, input logic adn, input logic cd,
                                        input logic fa, input logic [2:0] fs, input logic fd);
        return {mr, pu, sd, hw, prd, pwr, wbrd, bt, ws, awe, adn, cd, fa, fs, fd};
    endfunction

    function automatic logic [19:0] f_resp(input logic [1:0] hw, input logic sd);
        return rec(1'b1, 1'b1, sd, hw, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    endfunction

    function automatic logic [19:0] f_beat(input logic prd, input logic pwr, input logic [1:0] bt,
                                           input logic [1:0] ws, input logic awe, input logic adn,
                                           input logic cd, input logic fa, input logic [2:0] fs);
        return rec(1'b0, 1'b0, 1'b0, 2'd0, prd, pwr, pwr, bt, ws, awe, adn, cd, fa, fs, 1'b0);
    endfunction

    function automatic logic [31:0] st(input logic prd, input logic pwr, input logic wbrd,
                                       input logic awe, input logic adn, input logic cd,
                                       input logic fa, input logic fd, input logic [1:0] bt,
                                       input logic [1:0] ws, input logic [2:0] fs);
        return {17'd0, prd, pwr, wbrd, awe, adn, cd, fa, fd, bt, ws, fs};
    endfunction

    // Memory side: responds every cycle, or every other cycle in mode 1.
    initial begin
        pmem_resp = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_mode == 0) pmem_resp = 1'b1;
            else pmem_resp = ~pmem_resp;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response, beat or flush_done.
    logic [19:0] obs, expv;
    logic        rev, bev;
    logic [31:0] got;
    always @(negedge clk) begin
        if (flush_active) fa_cnt++;
        if (flush_done) fd_cnt++;
        if (alloc_done) ad_cnt++;
        rev = mem_resp | plru_update | set_dirty;
        bev = (pmem_resp && (pmem_read || pmem_write)) || alloc_we || alloc_done || clear_dirty;
        obs = '0;
        if (rev) obs = rec(mem_resp, plru_update, set_dirty, hit_way, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                           1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        if (bev) obs = obs | rec(1'b0, 1'b0, 1'b0, 2'd0, pmem_read, pmem_write, wb_rd, beat, way_sel,
                                 alloc_we, alloc_done, clear_dirty, flush_active,
                                 flush_active ? flush_set : 3'd0, 1'b0);
        if (flush_done) obs[0] = 1'b1;
        if (rev || bev || flush_done) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event got=%h required=none", obs);
            end else begin
                expv = exp_q.pop_front();
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL event got=%h required=%h at %0t", obs, expv, $time);
                end
            end
        end
        if (pmem_read || pmem_write) begin
            n_chk++;
            if (pmem_read && pmem_write) begin
                n_fail++;
                $display("FAIL pmem_overlap got=both required=one at %0t", $time);
            end
        end
        if (probe_kind != 0) begin
            case (probe_kind)
                1:       got = st(pmem_read, pmem_write, wb_rd, alloc_we, alloc_done, clear_dirty,
                                  flush_active, flush_done, beat, way_sel, flush_set);
                2:       got = fa_cnt;
                3:       got = fd_cnt;
                4:       got = exp_q.size();
                default: got = ad_cnt;
            endcase
            n_chk++;
            if (got !== probe_exp) begin
                n_fail++;
                $display("FAIL %s got=%0h required=%0h", probe_name, got, probe_exp);
            end
        end
    end

    logic       fill_pend, saw_resp, saw_fd, f_cleared, flush_mode, rst_at2, saw_rst;
    logic [1:0] fill_way;

    // One clock: sample at negedge, then update the datapath model at posedge+1.
    task automatic cycle();
        @(negedge clk);
        if (alloc_done) begin
            fill_pend = 1'b1;
            fill_way  = way_sel;
        end
        if (clear_dirty) f_cleared = 1'b1;
        saw_resp = mem_resp;
        saw_fd   = flush_done;
        if (rst_at2 && pmem_read && beat == 2'd2) begin
            rst_n   = 1'b0;
            rst_at2 = 1'b0;
            saw_rst = 1'b1;
        end
        @(posedge clk);
        #1;
        probe_kind = 0;
        if (fill_pend) begin
            hit[fill_way]   = 1'b1;
            valid[fill_way] = 1'b1;
            dirty[fill_way] = 1'b0;
            fill_pend       = 1'b0;
        end
        if (flush_active) flush_req = 1'b0;
        if (flush_mode) dirty = (flush_active && flush_set == 3'd5 && !f_cleared) ? 4'b0010 : 4'b0000;
        if (saw_resp) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            hit       = 4'b0000;
        end
    endtask

    task automatic run(input int max);
        for (int i = 0; i < max; i++) begin
            cycle();
            if (saw_resp) break;
        end
    endtask

    task automatic probe(input int kind, input logic [31:0] e, input string name);
        probe_kind = kind;
        probe_exp  = e;
        probe_name = name;
        cycle();
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; hit = 4'b0000; valid = 4'hF;
        dirty = 4'h0; plru_way = 2'd0; flush_req = 1'b0; probe_exp = '0; probe_name = "";
        fill_pend = 1'b0; fill_way = 2'd0; saw_resp = 1'b0; saw_fd = 1'b0; f_cleared = 1'b0;
        flush_mode = 1'b0; rst_at2 = 1'b0; saw_rst = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        probe(1, st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0), "reset_state");
        rst_n = 1'b1;
        cycle();

        // Hits: write, read with two ways matching, read+write together.
        exp_q.push_back(f_resp(2'd2, 1'b1));
        hit = 4'b0100; mem_write = 1'b1;
        run(5);
        exp_q.push_back(f_resp(2'd1, 1'b0));
        hit = 4'b1010; mem_read = 1'b1;
        run(5);
        exp_q.push_back(f_resp(2'd3, 1'b1));
        hit = 4'b1000; mem_read = 1'b1; mem_write = 1'b1;
        run(5);
        probe(1, st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0), "stray_resp_idle");

        // Clean miss into the invalid way 2.
        valid = 4'b1011; dirty = 4'h0; hit = 4'b0000;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(f_beat(1'b1, 1'b0, 2'(i), 2'd2, 1'b1, i == 3, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(f_resp(2'd2, 1'b0));
        mem_read = 1'b1;
        run(20);

        // Dirty miss on PLRU way 3 with a slow memory.
        resp_mode = 1;
        valid = 4'hF; dirty = 4'b1000; plru_way = 2'd3; hit = 4'b0000;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(f_beat(1'b0, 1'b1, 2'(i), 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
        for (int i = 0; i < 4; i++)
            exp_q.push_back(f_beat(1'b1, 1'b0, 2'(i), 2'd3, 1'b1, i == 3, 1'b0, 1'b0, 3'd0));
        exp_q.push_back(f_resp(2'd3, 1'b0));
        mem_read = 1'b1;
        run(40);
        resp_mode = 0;
        cycle();

        // Request beats flush entry, then a flush with set 5 way 1 dirty.
        valid = 4'hF; dirty = 4'h0; hit = 4'b0001; f_cleared = 1'b0; flush_mode = 1'b1;
        exp_q.push_back(f_resp(2'd0, 1'b0));
        for (int i = 0; i < 4; i++)
            exp_q.push_back(f_beat(1'b0, 1'b1, 2'(i), 2'd1, 1'b0, 1'b0, i == 3, 1'b1, 3'd5));
        exp_q.push_back(rec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                            1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
        mem_read = 1'b1; flush_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (saw_fd) break;
        end
        flush_mode = 1'b0;
        cycle();
        cycle();
        probe(2, 32'd36, "flush_active_cycles");
        probe(3, 32'd1, "flush_done_pulses");
        probe(1, st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0), "after_flush");

        // Reset during beat 2 of an allocate.
        valid = 4'b1011; dirty = 4'h0; hit = 4'b0000;
        for (int i = 0; i < 3; i++)
            exp_q.push_back(f_beat(1'b1, 1'b0, 2'(i), 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0));
        rst_at2 = 1'b1; mem_read = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (saw_rst) break;
        end
        mem_read = 1'b0;
        probe(1, st(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 3'd0), "reset_mid_alloc");
        rst_n = 1'b1;
        cycle();
        probe(5, 32'd2, "alloc_done_total");
        probe(4, 32'd0, "scoreboard_drained");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_control_nway.md
# cache_control_nway

Parametrised N-way, write-back cache controller FSM. It is the next generation of the 2-way cache controller. It sits between the CPU-side request interface and physical memory, and drives the cache datapath: victim selection, multi-beat write-back and allocate bursts, hit response, PLRU update, and a full-cache flush walk. The datapath keeps tag, valid, dirty and data arrays with combinational reads and provides the PLRU victim. This block owns all sequencing.

## Interface
Parameters:
- NUM_WAYS, 4, associativity; power of two, ≥2. WAY_W = clog2(NUM_WAYS).
- NUM_SETS, 8, sets walked during flush; power of two, ≥2. SET_W = clog2(NUM_SETS).
- BURST_LEN, 4, memory beats per line; ≥1. BEAT_W = max(1, clog2(BURST_LEN)).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- mem_read / mem_write  in  1 each  CPU request, held until mem_resp
- mem_resp  out  1  CPU request complete (combinational, IDLE hit only)
- hit  in  NUM_WAYS  per-way tag match for the current index
- valid / dirty  in  NUM_WAYS each  per-way state for the current index
- plru_way  in  WAY_W  PLRU victim for the current index
- hit_way  out  WAY_W  encoded hit way
- plru_update  out  1  touch hit_way in the PLRU
- set_dirty  out  1  mark hit_way dirty (write hit)
- way_sel  out  WAY_W  latched victim/flush way for the datapath
- beat  out  BEAT_W  current burst beat
- wb_rd  out  1  datapath drives way_sel line, beat to memory
- alloc_we  out  1  write memory beat into way_sel, beat
- alloc_done  out  1  last beat written: set valid, load tag, clear dirty
- clear_dirty  out  1  clear dirty of way_sel at flush_set
- flush_req  in  1  level request for a full flush
- flush_active  out  1  datapath indexes with flush_set instead of the CPU address
- flush_set  out  SET_W  set under flush
- flush_done  out  1  one-cycle pulse at the end of the flush
- pmem_read / pmem_write  out  1 each  memory burst request, held for the whole burst
- pmem_resp  in  1  one beat accepted or returned

## Operation
- States: IDLE, WRITE_BACK, ALLOCATE, FLUSH_SCAN, FLUSH_WB.
- **IDLE, request with any hit:**
  - Assert mem_resp and plru_update in the same cycle.
  - Assert set_dirty if mem_write.
  - hit_way is the lowest set bit of hit.
  - Remain in IDLE.
- **IDLE, request with no hit:**
  - The victim is the lowest-index invalid way if any way is invalid, else plru_way.
  - The victim is latched into way_sel.
  - If valid[v] and dirty[v], go to WRITE_BACK. Otherwise go to ALLOCATE.
- **WRITE_BACK:**
  - Assert pmem_write and wb_rd.
  - Each pmem_resp increments beat.
  - pmem_resp on beat == BURST_LEN-1 resets beat to 0 and moves to ALLOCATE.
- **ALLOCATE:**
  - Assert pmem_read. alloc_we = pmem_resp.
  - On the last beat, assert alloc_done, reset beat, and go to IDLE.
  - The request is still pending in IDLE, so it then hits and responds.
- **Flush entry:** flush_req in IDLE with no mem_read/mem_write goes to FLUSH_SCAN with flush_set = 0 and way_sel = 0. CPU requests take priority over flush entry.
- **FLUSH_SCAN:**
  - Assert flush_active.
  - If valid[way_sel] and dirty[way_sel], go to FLUSH_WB.
  - Otherwise advance way_sel. On way wrap, advance flush_set.
  - After set NUM_SETS-1, way NUM_WAYS-1: pulse flush_done and go to IDLE.
- **FLUSH_WB:**
  - Perform a burst identical to WRITE_BACK, with flush_active held.
  - On the last beat, assert clear_dirty, then advance (set, way) as in FLUSH_SCAN, including the completion case.
- pmem_resp outside WRITE_BACK, ALLOCATE and FLUSH_WB is ignored.
- mem_read and mem_write asserted together are treated as a write.
- CPU requests arriving during a flush wait; mem_resp stays 0 until the flush completes.

## Timing
- Reset (rst_n low at a clock edge):
  - State goes to IDLE. beat, way_sel and flush_set go to 0.
  - All registered-state-derived outputs are 0 the cycle after: pmem_*, wb_rd, alloc_*, clear_dirty, flush_*.
  - IDLE-combinational outputs (mem_resp, plru_update, set_dirty, hit_way) follow their inputs.
  - Reset mid-burst abandons the burst: the memory request drops at that edge and no alloc_done is issued.
- Hit latency is 0 cycles (combinational mem_resp).
- Clean miss latency: 1 + BURST_LEN×(memory beat latency) + 1 cycles, the last cycle being the IDLE hit.
- A dirty miss adds one full write-back burst.
- pmem_read and pmem_write are never asserted together. Each is asserted continuously from burst start to the cycle of the last pmem_resp.
- FLUSH_SCAN costs 1 cycle per (set, way). A full clean flush takes NUM_SETS×NUM_WAYS cycles before the flush_done cycle.

## Test plan
- **Write hit.** Defaults; hit=4'b0100, mem_write=1. Required: same cycle mem_resp=1, hit_way=2, plru_update=1, set_dirty=1; state stays IDLE.
- **Clean miss, invalid way.** valid=4'b1011, hit=0, mem_read. Required: way_sel=2, no pmem_write; pmem_read held across 4 resp beats with beat 0..3 and alloc_we on each; alloc_done on beat 3; then IDLE, and the forced hit gives mem_resp.
- **Dirty miss.** valid=4'hF, dirty=4'b1000, plru_way=3. Required: 4-beat write-back with wb_rd, then a 4-beat allocate to way 3; pmem_read and pmem_write never overlap.
- **Flush.** NUM_SETS=8, the only dirty line is set 5 way 1. Required: one 4-beat FLUSH_WB with flush_set=5, way_sel=1, and clear_dirty on the last beat; flush_done pulses exactly once after the (7,3) scan; total cycles = 32 scan + 4 beats.
- **Priority and stray response.** flush_req and mem_read both high in IDLE: the request is served first. A stray pmem_resp in IDLE causes no state change.
- **Reset mid-operation.** rst_n low during beat 2 of ALLOCATE: the next cycle is IDLE, beat=0, pmem_read=0, and alloc_done is never asserted.
